// File: rtl/axis_s2mm_capture_gate.sv
// Capture gate between a free-running sample stream and a DataMover S2MM port.
// Buffers a fixed number of beats and tags tlast at every command boundary.
module axis_s2mm_capture_gate #(
  parameter int DATA_WIDTH  = 256,
  parameter int BURST_BEATS = 128,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  input  logic                    write_start,
  input  logic                    write_reset,
  input  logic [31:0]             cap_size,
  output logic                    busy,
  output logic                    data_done,
  output logic                    overflow,
  output logic [15:0]             drop_cnt
);

  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int BW         = $clog2(BURST_BEATS) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_BEATS - 1);
  localparam logic [PW:0]   CNT_FULL   = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t                  state;
  logic [31:0]             total_beats;
  logic [31:0]             enq_cnt;
  logic [31:0]             deq_cnt;
  logic [BW-1:0]           burst_idx;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW:0]             count;
  logic [DATA_WIDTH-1:0]   mem_data [FIFO_DEPTH];
  logic                    mem_last [FIFO_DEPTH];

  logic [31:0] req_beats;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;
  logic        final_beat;
  logic        tag_last;

  assign req_beats  = cap_size >> BYTE_SHIFT;
  assign full       = (count == CNT_FULL);
  assign pop        = m_axis_tvalid && m_axis_tready;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push       = (state == CAPTURE) && s_axis_tvalid && (!full || pop);
  assign drop       = (state == CAPTURE) && s_axis_tvalid && full && !pop;
  assign final_beat = (enq_cnt == total_beats - 32'd1);
  assign tag_last   = (burst_idx == BURST_LAST) || final_beat;

  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem_data[rd_ptr] : '0;
  assign m_axis_tlast  = m_axis_tvalid && mem_last[rd_ptr];
  assign m_axis_tkeep  = '1;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= s_axis_tdata;
      mem_last[wr_ptr] <= tag_last;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      total_beats <= '0;
      enq_cnt     <= '0;
      deq_cnt     <= '0;
      burst_idx   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      busy        <= 1'b0;
      data_done   <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else if (write_reset) begin
      state       <= IDLE;
      total_beats <= '0;
      enq_cnt     <= '0;
      deq_cnt     <= '0;
      burst_idx   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      busy        <= 1'b0;
      data_done   <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        deq_cnt <= deq_cnt + 32'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (write_start && req_beats != 32'd0) begin
            state       <= CAPTURE;
            total_beats <= req_beats;
            enq_cnt     <= '0;
            deq_cnt     <= '0;
            burst_idx   <= '0;
            busy        <= 1'b1;
          end
        end
        CAPTURE: begin
          if (push) begin
            enq_cnt   <= enq_cnt + 32'd1;
            burst_idx <= tag_last ? '0 : burst_idx + BW'(1);
            if (final_beat) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The final beat was the last one enqueued, so its pop ends the capture.
          if (pop && deq_cnt == total_beats - 32'd1) begin
            state     <= DONE;
            data_done <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_s2mm_capture_gate.sv
// Randomized bench for axis_s2mm_capture_gate against a queue-based reference
// model built from the capture rules (beat index arithmetic, bounded buffer).
module tb_axis_s2mm_capture_gate;

  localparam int DW = 256;
  localparam int BB = 128;
  localparam int FD = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [DW/8-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          write_start = 1'b0;
  logic          write_reset = 1'b0;
  logic [31:0]   cap_size = '0;
  logic          busy;
  logic          data_done;
  logic          overflow;
  logic [15:0]   drop_cnt;

  axis_s2mm_capture_gate #(.DATA_WIDTH(DW), .BURST_BEATS(BB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .resetn(resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .write_start(write_start), .write_reset(write_reset), .cap_size(cap_size),
    .busy(busy), .data_done(data_done), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  // Reference model: phase 0 idle, 1 capturing, 2 draining, 3 done.
  beat_t q[$];
  int    phase = 0;
  int    total = 0;
  int    nin = 0;
  int    nout = 0;
  bit    m_busy = 0;
  bit    m_done = 0;
  bit    m_ovf = 0;
  int    m_drops = 0;

  int out_idx = 0;
  int last_idx[$];

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_model();
    q.delete();
    phase = 0; total = 0; nin = 0; nout = 0;
    m_busy = 0; m_done = 0; m_ovf = 0; m_drops = 0;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model across the edge.
  task automatic apply_stimulus();
    int  old;
    int  ph;
    bit  do_pop;
    beat_t b;
    @(negedge clk);
    check_output("tvalid", DW'(m_axis_tvalid), DW'(q.size() != 0));
    check_output("busy", DW'(busy), DW'(m_busy));
    check_output("data_done", DW'(data_done), DW'(m_done));
    check_output("overflow", DW'(overflow), DW'(m_ovf));
    check_output("drop_cnt", DW'(drop_cnt), DW'(m_drops));
    check_output("tkeep", DW'(m_axis_tkeep), DW'({(DW/8){1'b1}}));
    if (q.size() != 0) begin
      check_output("tdata", m_axis_tdata, q[0].data);
      check_output("tlast", DW'(m_axis_tlast), DW'(q[0].last));
    end
    if (!resetn) begin
      check_output("rst_tdata", m_axis_tdata, '0);
      check_output("rst_tlast", DW'(m_axis_tlast), '0);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (m_axis_tlast) last_idx.push_back(out_idx);
      out_idx++;
    end

    if (!resetn || write_reset) begin
      clear_model();
    end else begin
      old    = q.size();
      ph     = phase;
      do_pop = (old > 0) && m_axis_tready;
      if (do_pop) begin
        void'(q.pop_front());
        nout++;
      end
      if (ph == 0) begin
        if (write_start && int'(cap_size >> 5) != 0) begin
          phase = 1; total = int'(cap_size >> 5); nin = 0; nout = 0; m_busy = 1;
        end
      end else if (ph == 1 && s_axis_tvalid) begin
        if (old < FD || do_pop) begin
          b.data = s_axis_tdata;
          b.last = ((nin + 1) % BB == 0) || (nin == total - 1);
          q.push_back(b);
          nin++;
          if (nin == total) phase = 2;
        end else begin
          m_ovf = 1;
          if (m_drops < 16'hFFFF) m_drops++;
        end
      end else if (ph == 2 && do_pop && nout == total) begin
        phase = 3; m_done = 1; m_busy = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // vmode: 0 continuous, 1 random valid. rmode: 0 ready high, 1 random,
  // 2 low for the first 30 cycles, 3 alternating near-full / near-empty bias.
  task automatic run_capture(input int cap, input int vmode, input int rmode,
                             input int abort_at);
    int n;
    int cyc;
    n = cap >> 5;
    out_idx = 0;
    last_idx.delete();
    cap_size    = cap;
    write_start = 1'b1;
    apply_stimulus();
    write_start = 1'b0;
    cyc = 0;
    while (!data_done && cyc < 20000) begin
      if (abort_at >= 0 && out_idx == abort_at) break;
      s_axis_tvalid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
      case (rmode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = $urandom_range(0, 1) == 1;
        2:       m_axis_tready = (cyc >= 30);
        default: m_axis_tready = ((cyc / 40) % 2 == 0) ? ($urandom_range(0, 7) == 0)
                                                       : ($urandom_range(0, 7) != 0);
      endcase
      write_start = ($urandom_range(0, 15) == 0);
      cap_size    = $urandom;
      apply_stimulus();
      cyc++;
    end
    write_start = 1'b0;
    if (abort_at < 0) begin
      check_output("done_flag", DW'(data_done), DW'(1));
      check_output("beats_out", DW'(out_idx), DW'(n));
      check_output("tlast_count", DW'(last_idx.size()), DW'((n + BB - 1) / BB));
      if (last_idx.size() > 0) begin
        check_output("first_tlast", DW'(last_idx[0]), DW'(((n < BB) ? n : BB) - 1));
        check_output("final_tlast", DW'(last_idx[last_idx.size() - 1]), DW'(n - 1));
      end
      if (rmode == 2) begin
        check_output("ovf_flag", DW'(overflow), DW'(1));
        check_output("ovf_drops", DW'(drop_cnt), DW'(14));
      end
      // A fresh start while finished must be ignored.
      cap_size    = 32'd8192;
      write_start = 1'b1;
      apply_stimulus();
      apply_stimulus();
      write_start = 1'b0;
      check_output("done_hold", DW'(data_done), DW'(1));
    end else begin
      check_output("abort_point", DW'(out_idx), DW'(abort_at));
    end
    s_axis_tvalid = 1'b1;
    write_reset   = 1'b1;
    apply_stimulus();
    write_reset   = 1'b0;
    apply_stimulus();
    check_output("post_reset_busy", DW'(busy), DW'(0));
    check_output("post_reset_valid", DW'(m_axis_tvalid), DW'(0));
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    s_axis_tdata  = {8{32'hA5A5_5A5A}};
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus();
    resetn = 1'b1;
    apply_stimulus();

    run_capture(8192, 0, 0, -1);
    run_capture(4128, 0, 0, -1);
    run_capture(96, 0, 0, -1);
    run_capture(32, 0, 0, -1);
    run_capture(4096 + 17, 1, 1, -1);

    // Sub-beat capture length: start is ignored, nothing comes out.
    out_idx = 0;
    cap_size = 32'd16;
    write_start = 1'b1;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) apply_stimulus();
    write_start = 1'b0;
    check_output("tiny_busy", DW'(busy), DW'(0));
    check_output("tiny_beats", DW'(out_idx), DW'(0));

    run_capture(8192, 0, 2, -1);
    run_capture(8192, 0, 0, 50);
    run_capture(8192, 0, 0, -1);

    for (int i = 0; i < 4; i++)
      run_capture($urandom_range(1, 400) * 32 + $urandom_range(0, 31), 1, 3, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
